// File: rtl/sst_seq_pkg.sv
// Shared mapper save-state definitions: bus typedef, sequencer states and
// the default slot count / tag-slot location.
package sst_seq_pkg;

  localparam int REG_NUM_DEF = 128;
  localparam int M2_WAIT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SV_WAIT,
    SV_WR,
    LD_TAG,
    LD_RD,
    LD_WAIT,
    FIN
  } sst_state_t;

  typedef struct packed {
    logic       act;
    logic [7:0] addr;
    logic       we_reg;
    logic [7:0] dato;
  } sst_bus_t;

  // The last slot carries the mapper index used to validate a load.
  function automatic logic [7:0] sst_tag_slot(input int reg_num);
    return 8'(reg_num - 1);
  endfunction

endpackage

// File: rtl/m2_edge.sv
// Synchronises cpu.m2 into clk and emits a one-cycle pulse per falling edge.
// Lives in the parent beside sst_seq, which consumes m2_fall.
module m2_edge (
  input  logic clk,
  input  logic map_rst_n,
  input  logic m2,
  output logic m2_fall
);

  logic [2:0] m2_sync;

  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      m2_sync <= '0;
      m2_fall <= 1'b0;
    end else begin
      m2_sync <= {m2_sync[1:0], m2};
      m2_fall <= m2_sync[2] & ~m2_sync[1];
    end
  end

endmodule

// File: rtl/sst_seq.sv
// Save-state sequencer: walks the mapper registers on m2 falling edges,
// copying them to the buffer (save) or restoring them after a tag check (load).
//
// state   | meaning
// IDLE    | waiting for save_req / load_req, save_state mode off
// SETTLE  | counting M2_WAIT m2 falls before the first access
// SV_WAIT | sst_addr=index, waiting for m2_fall
// SV_WR   | buffer[index] <= sst_di
// LD_TAG  | read tag slot, compare to map_idx one clk later
// LD_RD   | read buffer[index], latch into sst_dato one clk later
// LD_WAIT | sst_we_reg held until the mapper takes it on m2_fall
// FIN     | done pulse, back to IDLE
module sst_seq
  import sst_seq_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int M2_WAIT = M2_WAIT_DEF
) (
  input  logic       clk,
  input  logic       map_rst_n,
  input  logic       m2_fall,
  input  logic       save_req,
  input  logic       load_req,
  input  logic [7:0] map_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [6:0] buf_addr,
  output logic       buf_we,
  output logic [7:0] buf_wdat,
  input  logic [7:0] buf_rdat
);

  localparam logic [7:0] LAST_SV  = sst_tag_slot(REG_NUM);
  localparam logic [7:0] LAST_LD  = 8'(REG_NUM - 2);
  localparam logic [6:0] TAG_ADDR = LAST_SV[6:0];
  localparam logic [7:0] SETTLE_N = 8'(M2_WAIT);

  sst_state_t state, state_d;
  logic [7:0] index, index_d;
  logic [7:0] settle_cnt, settle_cnt_d;
  logic       load_mode, load_mode_d;
  logic       rd_pend, rd_pend_d;
  logic       we_q, we_d;
  logic [7:0] dato_q, dato_d;
  sst_bus_t   sst_bus;

  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      state      <= IDLE;
      index      <= '0;
      settle_cnt <= '0;
      load_mode  <= 1'b0;
      rd_pend    <= 1'b0;
      we_q       <= 1'b0;
      dato_q     <= '0;
    end else begin
      state      <= state_d;
      index      <= index_d;
      settle_cnt <= settle_cnt_d;
      load_mode  <= load_mode_d;
      rd_pend    <= rd_pend_d;
      we_q       <= we_d;
      dato_q     <= dato_d;
    end
  end

  always_comb begin
    state_d      = state;
    index_d      = index;
    settle_cnt_d = settle_cnt;
    load_mode_d  = load_mode;
    rd_pend_d    = rd_pend;
    we_d         = we_q;
    dato_d       = dato_q;
    done         = 1'b0;
    err          = 1'b0;
    buf_we       = 1'b0;
    buf_addr     = index[6:0];
    buf_wdat     = '0;

    case (state)
      IDLE: begin
        index_d   = '0;
        rd_pend_d = 1'b0;
        // save has priority when both requests land together
        if (save_req) begin
          state_d      = SETTLE;
          load_mode_d  = 1'b0;
          settle_cnt_d = SETTLE_N;
        end else if (load_req) begin
          state_d      = SETTLE;
          load_mode_d  = 1'b1;
          settle_cnt_d = SETTLE_N;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          state_d = load_mode ? LD_TAG : SV_WAIT;
          index_d = '0;
        end else if (m2_fall) begin
          settle_cnt_d = settle_cnt - 8'd1;
        end
      end
      SV_WAIT: begin
        if (m2_fall) state_d = SV_WR;
      end
      SV_WR: begin
        buf_we   = 1'b1;
        buf_wdat = sst_di;
        if (index == LAST_SV) begin
          state_d = FIN;
        end else begin
          index_d = index + 8'd1;
          state_d = SV_WAIT;
        end
      end
      LD_TAG: begin
        buf_addr = TAG_ADDR;
        if (!rd_pend) begin
          rd_pend_d = 1'b1;
        end else begin
          rd_pend_d = 1'b0;
          index_d   = '0;
          if (buf_rdat != map_idx) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LD_RD;
          end
        end
      end
      LD_RD: begin
        if (!rd_pend) begin
          rd_pend_d = 1'b1;
        end else begin
          rd_pend_d = 1'b0;
          dato_d    = buf_rdat;
          we_d      = 1'b1;
          state_d   = LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (m2_fall) begin
          we_d   = 1'b0;
          dato_d = '0;
          // tag slot is never restored, so the walk stops one short
          if (index == LAST_LD) begin
            state_d = FIN;
          end else begin
            index_d = index + 8'd1;
            state_d = LD_RD;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        index_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign sst_bus = '{act: busy, addr: index, we_reg: we_q, dato: dato_q};

  assign sst_act    = sst_bus.act;
  assign sst_addr   = sst_bus.addr;
  assign sst_we_reg = sst_bus.we_reg;
  assign sst_dato   = sst_bus.dato;

endmodule
